// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   owner_e : who owns the memory access issued in a given cycle
//   CNT_W   : width of the DMA starvation counter
package dmem_arb_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

endpackage

// File: rtl/dmem_arb_starve.sv
// DMA starvation counter for the data-memory arbiter.
// Counts consecutive contested cycles that DMA loses. Once the count reaches
// StarveLim, force_dma_o hands DMA the next contested cycle.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   cpu_req_i     : CPU is requesting this cycle
//   dma_req_i     : DMA is requesting this cycle
//   dma_win_i     : DMA is granted this cycle
//   force_dma_o   : DMA must win a contest this cycle
module dmem_arb_starve
   import dmem_arb_pkg::*;
#(
   parameter int unsigned StarveLim = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic cpu_req_i,
   input  logic dma_req_i,
   input  logic dma_win_i,
   output logic force_dma_o
);

   localparam logic [CNT_W-1:0] Lim = CNT_W'(StarveLim);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      // Only a contested cycle that DMA loses advances the count; DMA idle or
      // served (which includes uncontested DMA cycles) clears it.
      if (dma_req_i && cpu_req_i && !dma_win_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_dma_o = (cnt_q == Lim);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between a CPU and a DMA/loader.
// CPU wins contests; with macro DMEM_ARB_FAIR_EN defined, a starvation counter
// hands DMA one contested cycle after STARVE_LIM consecutive losses. Without
// it, priority is strictly CPU-first.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            : CPU request
//   cpu_stall, cpu_rdata, cpu_rvalid : CPU not-served flag, load return
//   dma_req/we/addr/wdata            : DMA request
//   dma_gnt, dma_rdata, dma_rvalid   : DMA grant, load return
//   mem_en/we/addr/wdata, mem_rdata  : memory command, read data (1-cycle)
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_lim
      $error("dmem_arbiter: STARVE_LIM must be in 1..15");
   end

   owner_e            own_q, own_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              cpu_win, dma_win, force_dma;

`ifdef DMEM_ARB_FAIR_EN
   dmem_arb_starve #(
      .StarveLim (STARVE_LIM)
   ) u_starve (
      .clk_i       (clk),
      .rst_i       (rst),
      .cpu_req_i   (cpu_req),
      .dma_req_i   (dma_req),
      .dma_win_i   (dma_win),
      .force_dma_o (force_dma)
   );
`else
   assign force_dma = 1'b0;
`endif

   always_comb begin
      // Nobody is granted while in reset.
      cpu_win = !rst && cpu_req && !(dma_req && force_dma);
      dma_win = !rst && dma_req && !cpu_win;

      cpu_stall = cpu_req && !cpu_win;
      dma_gnt   = dma_win;

      mem_en    = cpu_win || dma_win;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      own_d     = OWN_NONE;
      we_d      = 1'b0;
      if (cpu_win) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         own_d     = OWN_CPU;
         we_d      = cpu_we;
      end else if (dma_win) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         own_d     = OWN_DMA;
         we_d      = dma_we;
      end

      // Read data returns the cycle after the grant; gating with rst drops a
      // read that was in flight when reset arrived.
      cpu_rvalid = !rst && (own_q == OWN_CPU) && !we_q;
      dma_rvalid = !rst && (own_q == OWN_DMA) && !we_q;

      cpu_rdata = rst ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
      dma_rdata = rst ? '0 : (dma_rvalid ? mem_rdata : dma_rdata_q);
      cpu_rdata_d = cpu_rdata;
      dma_rdata_d = dma_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         own_q       <= OWN_NONE;
         we_q        <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         own_q       <= own_d;
         we_q        <= we_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps, a behavioural memory,
// and a scoreboard of expected read returns (one entry per granted cycle).
// Fairness expectations follow DMEM_ARB_FAIR_EN when it is defined.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

`ifdef DMEM_ARB_FAIR_EN
   localparam bit Fair = 1'b1;
`else
   localparam bit Fair = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic        dma_gnt, dma_rvalid;
   logic [31:0] dma_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_stall  (cpu_stall),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Memory with one-cycle read latency, driven only by the DUT command.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   typedef struct {
      owner_e      own;
      logic [31:0] data;
   } ret_t;

   ret_t        sbq[$];
   logic [31:0] exp_mem [int];
   logic [31:0] last_cpu = '0, last_dma = '0;
   int          n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive requests, check returns of the previous cycle,
   // check this cycle's grant/command against the expected winner.
   task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd,
                       input owner_e win, input string tag);
      ret_t        e;
      logic        ewe;
      logic [31:0] ea, ed;
      @(negedge clk);
      rst = 1'b0;
      cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
      dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
      #1;
      e.own  = OWN_NONE;
      e.data = '0;
      if (sbq.size() > 0) e = sbq.pop_front();
      if (e.own == OWN_CPU) last_cpu = e.data;
      if (e.own == OWN_DMA) last_dma = e.data;
      chk({tag, ".cpu_rvalid"}, 64'(cpu_rvalid), 64'(e.own == OWN_CPU));
      chk({tag, ".dma_rvalid"}, 64'(dma_rvalid), 64'(e.own == OWN_DMA));
      chk({tag, ".cpu_rdata"},  64'(cpu_rdata),  64'(last_cpu));
      chk({tag, ".dma_rdata"},  64'(dma_rdata),  64'(last_dma));

      ewe = 1'b0; ea = '0; ed = '0;
      if (win == OWN_CPU) begin ewe = cwe; ea = caddr; ed = cwd; end
      if (win == OWN_DMA) begin ewe = dwe; ea = daddr; ed = dwd; end
      chk({tag, ".cpu_stall"}, 64'(cpu_stall), 64'(creq && win != OWN_CPU));
      chk({tag, ".dma_gnt"},   64'(dma_gnt),   64'(win == OWN_DMA));
      chk({tag, ".mem_en"},    64'(mem_en),    64'(win != OWN_NONE));
      chk({tag, ".mem_we"},    64'(mem_we),    64'(ewe));
      chk({tag, ".mem_addr"},  64'(mem_addr),  64'(ea));
      chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(ed));

      e.own  = OWN_NONE;
      e.data = '0;
      if (win != OWN_NONE && ewe) exp_mem[int'(ea)] = ed;
      if (win != OWN_NONE && !ewe) begin
         e.own  = win;
         e.data = exp_mem.exists(int'(ea)) ? exp_mem[int'(ea)] : 32'h0;
      end
      sbq.push_back(e);
   endtask

   task automatic do_reset(input logic creq, input logic dreq, input string tag);
      @(negedge clk);
      rst = 1'b1;
      cpu_req = creq; cpu_we = 1'b0; cpu_addr = 32'h10;
      dma_req = dreq; dma_we = 1'b0; dma_addr = 32'h14;
      #1;
      chk({tag, ".cpu_stall"},  64'(cpu_stall),  64'(creq));
      chk({tag, ".dma_gnt"},    64'(dma_gnt),    64'(0));
      chk({tag, ".mem_en"},     64'(mem_en),     64'(0));
      chk({tag, ".mem_addr"},   64'(mem_addr),   64'(0));
      chk({tag, ".cpu_rvalid"}, 64'(cpu_rvalid), 64'(0));
      chk({tag, ".dma_rvalid"}, 64'(dma_rvalid), 64'(0));
      chk({tag, ".cpu_rdata"},  64'(cpu_rdata),  64'(0));
      chk({tag, ".dma_rdata"},  64'(dma_rdata),  64'(0));
      sbq.delete();
      last_cpu = '0;
      last_dma = '0;
   endtask

   // Both sides reading continuously; CPU 0x10, DMA 0x14.
   task automatic contest(input owner_e win, input string tag);
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, win, tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, OWN_NONE, tag);
   endtask

   initial begin
      do_reset(1'b1, 1'b1, "rst_a");
      do_reset(1'b0, 1'b0, "rst_b");
      idle("idle0");

      // Preload through the DMA port.
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, OWN_DMA, "pre10");
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h12345678, OWN_DMA, "pre14");

      // CPU-only read, then DMA write with CPU idle.
      step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, OWN_CPU, "cpu_rd");
      idle("cpu_rd_ret");
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h000000AA, OWN_DMA, "dma_wr");
      idle("dma_wr_ret");
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, OWN_DMA, "dma_rd");

      // Alternating owners back to back.
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0)
            step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, OWN_CPU, "alt_cpu");
         else
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, OWN_DMA, "alt_dma");
      end

      // CPU write wins a contest against a DMA write, then reads it back.
      step(1'b1, 1'b1, 32'h30, 32'h0BADF00D, 1'b1, 1'b1, 32'h34, 32'h55, OWN_CPU, "cw_vs_dw");
      step(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, OWN_CPU, "cpu_rb");
      idle("drain0");

      // Continuous contest.
      for (int i = 0; i < 10; i++)
         contest((Fair && (i % 5 == 4)) ? OWN_DMA : OWN_CPU, "contest");
      idle("drain1");

      // Three losses, then DMA drops its request: the count must clear.
      for (int i = 0; i < 3; i++) contest(OWN_CPU, "lose3");
      for (int i = 0; i < 20; i++)
         step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, OWN_CPU, "cpu_only");
      for (int i = 0; i < 5; i++)
         contest((Fair && i == 4) ? OWN_DMA : OWN_CPU, "after_clr");
      idle("drain2");

      // Reset the cycle after a CPU read grant; count must restart at zero.
      contest(OWN_CPU, "pre_rst0");
      contest(OWN_CPU, "pre_rst1");
      contest(OWN_CPU, "pre_rst2");
      do_reset(1'b1, 1'b1, "rst_mid");
      for (int i = 0; i < 5; i++)
         contest((Fair && i == 4) ? OWN_DMA : OWN_CPU, "post_rst");
      idle("drain3");
      idle("drain4");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
